// File: rtl/usb_crc_pkg.sv
// rtl/usb_crc_pkg.sv - shared types and constants for the USB serial CRC engine
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND,
        DONE
    } crc_state_t;

    typedef enum logic {
        CRC_GEN,
        CRC_CHK
    } crc_mode_t;

    localparam logic [4:0]  CRC5_POLY     = 5'b00101;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/crc_lfsr_step.sv
// rtl/crc_lfsr_step.sv - combinational one-bit next state of an MSB-first CRC lfsr
module crc_lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '1
) (
    input  logic [WIDTH-1:0] lfsr,
    input  logic             din,
    output logic [WIDTH-1:0] next
);

    logic fb;

    assign fb   = din ^ lfsr[WIDTH-1];
    assign next = {lfsr[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_serial.sv
// rtl/usb_crc_serial.sv - bit-serial USB CRC5/CRC16 generator and checker
module usb_crc_serial
    import usb_crc_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC16_POLY),
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = WIDTH'(CRC16_RESIDUE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic crc_mode,
    input  logic crc_start,
    input  logic s_in,
    input  logic stall,
    output logic crc_out,
    output logic crc_ready,
    output logic crc_done,
    input  logic crc_rec,
    output logic crc_ok,
    output logic crc_err
);

    localparam int CW = $clog2(WIDTH + 1);

    crc_state_t       state;
    crc_mode_t        mode;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] step_src;
    logic [WIDTH-1:0] step_next;
    logic [CW-1:0]    cnt;
    logic             ok_q;
    logic             err_q;

    // The first bit of a packet is folded into the seed so it is not lost.
    assign step_src = (state == IDLE) ? INIT : lfsr;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .lfsr (step_src),
        .din  (s_in),
        .next (step_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= CRC_GEN;
            lfsr  <= INIT;
            cnt   <= '0;
            ok_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (crc_start) begin
                        lfsr  <= step_next;
                        mode  <= crc_mode_t'(crc_mode);
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (crc_start) begin
                        lfsr <= step_next;
                    end else if (mode == CRC_CHK) begin
                        state <= DONE;
                        ok_q  <= (lfsr == RESIDUE);
                        err_q <= (lfsr != RESIDUE);
                    end else begin
                        state <= SEND;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    lfsr <= {lfsr[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (crc_rec) begin
                        state <= IDLE;
                        lfsr  <= INIT;
                        cnt   <= '0;
                        ok_q  <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign crc_ready = (state == SEND);
    assign crc_done  = (state == DONE);
    assign crc_out   = (state == SEND) & ~lfsr[WIDTH-1];
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;

endmodule

// File: tb/tb_usb_crc_serial.sv
// tb/tb_usb_crc_serial.sv - directed self-checking bench for usb_crc_serial
module tb_usb_crc_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel16 = 1'b1;
    logic mode = 1'b0;
    logic start = 1'b0;
    logic sin = 1'b0;
    logic stl = 1'b0;
    logic rec = 1'b0;

    logic o16, r16, d16, ok16, er16;
    logic o5, r5, d5, ok5, er5;
    logic out, ready, done, ok, err;

    int errors = 0;
    int checks = 0;

    logic        data [0:127];
    logic [15:0] crc;
    int          sc;

    always #5 clk = ~clk;

    usb_crc_serial #(
        .WIDTH   (16),
        .POLY    (16'h8005),
        .INIT    (16'hFFFF),
        .RESIDUE (16'h800D)
    ) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .crc_mode  (sel16 & mode),
        .crc_start (sel16 & start),
        .s_in      (sel16 & sin),
        .stall     (sel16 & stl),
        .crc_out   (o16),
        .crc_ready (r16),
        .crc_done  (d16),
        .crc_rec   (sel16 & rec),
        .crc_ok    (ok16),
        .crc_err   (er16)
    );

    usb_crc_serial #(
        .WIDTH   (5),
        .POLY    (5'b00101),
        .INIT    (5'b11111),
        .RESIDUE (5'b01100)
    ) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .crc_mode  (~sel16 & mode),
        .crc_start (~sel16 & start),
        .s_in      (~sel16 & sin),
        .stall     (~sel16 & stl),
        .crc_out   (o5),
        .crc_ready (r5),
        .crc_done  (d5),
        .crc_rec   (~sel16 & rec),
        .crc_ok    (ok5),
        .crc_err   (er5)
    );

    assign out   = sel16 ? o16  : o5;
    assign ready = sel16 ? r16  : r5;
    assign done  = sel16 ? d16  : d5;
    assign ok    = sel16 ? ok16 : ok5;
    assign err   = sel16 ? er16 : er5;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC over data[0:nb-1], returned already complemented.
    function automatic logic [15:0] model(input int nb, input int w);
        logic [15:0] r;
        logic [15:0] poly;
        logic [15:0] mask;
        logic        fb;
        mask = (w == 16) ? 16'hFFFF : 16'h001F;
        poly = (w == 16) ? 16'h8005 : 16'h0005;
        r    = mask;
        for (int i = 0; i < nb; i++) begin
            fb = data[i] ^ r[w-1];
            r  = ((r << 1) ^ (fb ? poly : 16'h0)) & mask;
        end
        return ~r & mask;
    endfunction

    task automatic feed(input int nb, input int stall_at);
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                stl   = 1'b1;
                start = 1'b1;
                sin   = ~data[i];
                tick();
                stl = 1'b0;
            end
            start = 1'b1;
            sin   = data[i];
            tick();
        end
        start = 1'b0;
        sin   = 1'b0;
    endtask

    task automatic collect(input int w, input int stall_at, output logic [15:0] c, output int cyc);
        logic b;
        c   = '0;
        cyc = 0;
        tick();
        for (int k = 0; k < w; k++) begin
            chk("send_ready", {15'd0, ready}, 16'd1);
            b = out;
            c = {c[14:0], b};
            if (ready) cyc++;
            if (k == stall_at) begin
                stl = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    chk("stall_hold_out", {15'd0, out}, {15'd0, b});
                    if (ready) cyc++;
                end
                stl = 1'b0;
            end
            tick();
        end
        chk("after_send_ready", {15'd0, ready}, 16'd0);
        chk("after_send_done", {15'd0, done}, 16'd1);
    endtask

    task automatic ack();
        rec = 1'b1;
        tick();
        rec = 1'b0;
        chk("ack_done_clear", {12'd0, done, ready, ok, err}, 16'd0);
    endtask

    task automatic append(input int nb, input int w, input logic [15:0] c);
        for (int k = 0; k < w; k++) data[nb+k] = c[w-1-k];
    endtask

    initial begin
        repeat (2) tick();
        chk("reset16", {11'd0, o16, r16, d16, ok16, er16}, 16'd0);
        chk("reset5", {11'd0, o5, r5, d5, ok5, er5}, 16'd0);
        rst_n = 1'b1;
        tick();

        // CRC16, single 0 bit
        sel16 = 1'b1;
        mode = 1'b0;
        data[0] = 1'b0;
        feed(1, -1);
        collect(16, -1, crc, sc);
        chk("crc16_bit0", crc, 16'h8004);
        chk("crc16_bit0_len", 16'(sc), 16'd16);
        chk("gen_no_flags", {14'd0, ok, err}, 16'd0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("done_held", {15'd0, done}, 16'd1);
        ack();

        // CRC16, single 1 bit
        data[0] = 1'b1;
        feed(1, -1);
        collect(16, -1, crc, sc);
        chk("crc16_bit1", crc, 16'h0001);
        ack();

        // CRC5, single 0 bit
        sel16 = 1'b0;
        data[0] = 1'b0;
        feed(1, -1);
        collect(5, -1, crc, sc);
        chk("crc5_bit0", crc, 16'h0004);
        chk("crc5_bit0_len", 16'(sc), 16'd5);
        ack();

        // CRC16 loopback over 64 random bits
        sel16 = 1'b1;
        for (int i = 0; i < 64; i++) data[i] = 1'($urandom_range(0, 1));
        feed(64, -1);
        collect(16, -1, crc, sc);
        chk("crc16_rand", crc, model(64, 16));
        ack();
        append(64, 16, crc);
        mode = 1'b1;
        feed(80, -1);
        tick();
        chk("chk16_good", {13'd0, done, ok, err}, 16'b110);
        ack();
        data[37] = ~data[37];
        feed(80, -1);
        tick();
        chk("chk16_bad", {13'd0, done, ok, err}, 16'b101);
        ack();

        // CRC5 loopback over 11 random bits
        sel16 = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 11; i++) data[i] = 1'($urandom_range(0, 1));
        feed(11, -1);
        collect(5, -1, crc, sc);
        chk("crc5_rand", crc, model(11, 5));
        ack();
        append(11, 5, crc);
        mode = 1'b1;
        feed(16, -1);
        tick();
        chk("chk5_good", {13'd0, done, ok, err}, 16'b110);
        ack();
        data[14] = ~data[14];
        feed(16, -1);
        tick();
        chk("chk5_bad", {13'd0, done, ok, err}, 16'b101);
        ack();

        // Stall in CALC and SEND
        sel16 = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 32; i++) data[i] = 1'($urandom_range(0, 1));
        feed(32, 10);
        collect(16, 5, crc, sc);
        chk("crc16_stall", crc, model(32, 16));
        chk("stall_send_len", 16'(sc), 16'd18);
        ack();

        // Reset mid-SEND
        for (int i = 0; i < 20; i++) data[i] = 1'($urandom_range(0, 1));
        feed(20, -1);
        repeat (8) tick();
        chk("pre_reset_ready", {15'd0, ready}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {11'd0, out, ready, done, ok, err}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        data[0] = 1'b0;
        feed(1, -1);
        collect(16, -1, crc, sc);
        chk("crc16_after_abort", crc, 16'h8004);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
